// File: rtl/duck_pkg.sv
// rtl/duck_pkg.sv - shared state encoding, key colour and clamp helper for the duck sprite engine
package duck_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FLY    = 3'd1,
    ST_SHOT   = 3'd2,
    ST_FALL   = 3'd3,
    ST_ESCAPE = 3'd4
  } duck_state_t;

  localparam logic [23:0] KEY_COLOR_DEF = 24'h00ff00;

  function automatic logic [9:0] clamp10(input int v, input int lo, input int hi);
    if (v < lo) return 10'(lo);
    if (v > hi) return 10'(hi);
    return 10'(v);
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// rtl/sprite_addr_gen.sv - per-pixel sprite box test, mirroring and sheet address, with in_box delayed to line up with the ROM
module sprite_addr_gen
  import duck_pkg::*;
#(
  parameter int SPR_W        = 20,
  parameter int SPR_H        = 16,
  parameter int SHEET_STRIDE = 640,
  parameter int BASE_ADDR    = 550,
  parameter int ADDR_W       = 19
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        duck_x,
  input  logic [9:0]        duck_y,
  input  logic [2:0]        frame,
  input  logic              mirror,
  input  logic              visible,
  output logic [ADDR_W-1:0] read_address,
  output logic              in_box_q
);

  logic [10:0]       dx;
  logic [10:0]       dy;
  logic [10:0]       col;
  logic              in_box;
  logic [ADDR_W-1:0] addr_full;

  assign dx = {1'b0, DrawX} - {1'b0, duck_x};
  assign dy = {1'b0, DrawY} - {1'b0, duck_y};

  // A hidden duck never claims a pixel, so the address rests at the sheet origin.
  assign in_box = visible && (DrawX >= duck_x) && (dx < 11'(SPR_W))
               && (DrawY >= duck_y) && (dy < 11'(SPR_H));

  assign col = mirror ? (11'(SPR_W - 1) - dx) : dx;

  assign addr_full = ADDR_W'(BASE_ADDR)
                   + ADDR_W'(dy) * ADDR_W'(SHEET_STRIDE)
                   + ADDR_W'(frame) * ADDR_W'(SPR_W)
                   + ADDR_W'(col);

  assign read_address = in_box ? addr_full : ADDR_W'(BASE_ADDR);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) in_box_q <= 1'b0;
    else          in_box_q <= in_box;
  end

endmodule

// File: rtl/duck_sprite_engine.sv
// rtl/duck_sprite_engine.sv - one animated duck: life-cycle FSM, bounce motion, flap animation and sprite pixel output
module duck_sprite_engine
  import duck_pkg::*;
#(
  parameter int          SPR_W          = 20,
  parameter int          SPR_H          = 16,
  parameter int          SHEET_STRIDE   = 640,
  parameter int          BASE_ADDR      = 550,
  parameter int          NUM_FLY_FRAMES = 3,
  parameter int          ANIM_DIV       = 8,
  parameter int          X_STEP         = 2,
  parameter int          Y_STEP         = 1,
  parameter int          FALL_STEP      = 3,
  parameter int          X_MIN          = 0,
  parameter int          X_MAX          = 639,
  parameter int          Y_MIN          = 0,
  parameter int          Y_MAX          = 400,
  parameter int          FLY_TICKS      = 600,
  parameter int          SHOT_TICKS     = 30,
  parameter logic [23:0] KEY_COLOR      = KEY_COLOR_DEF,
  parameter int          ADDR_W         = 19
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_clk,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              launch,
  input  logic [9:0]        launch_x,
  input  logic              launch_left,
  input  logic              shot,
  input  logic [23:0]       rom_data,
  output logic [ADDR_W-1:0] read_address,
  output logic              is_duck,
  output logic [2:0]        duck_state,
  output logic              hit_pulse,
  output logic              landed_pulse,
  output logic              escaped_pulse
);

  localparam int X_HI = X_MAX - SPR_W + 1;
  localparam int Y_HI = Y_MAX - SPR_H + 1;

  duck_state_t state;
  logic        fc_q;
  logic        tick;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        dir_left;
  logic        dir_down;
  logic [15:0] fly_cnt;
  logic [15:0] shot_cnt;
  logic [15:0] anim_cnt;
  logic [2:0]  frame;
  logic        mirror;
  logic        visible;
  logic        in_box_q;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state         <= ST_IDLE;
      fc_q          <= 1'b0;
      tick          <= 1'b0;
      x             <= '0;
      y             <= '0;
      dir_left      <= 1'b0;
      dir_down      <= 1'b0;
      fly_cnt       <= '0;
      shot_cnt      <= '0;
      anim_cnt      <= '0;
      frame         <= '0;
      hit_pulse     <= 1'b0;
      landed_pulse  <= 1'b0;
      escaped_pulse <= 1'b0;
    end else begin
      fc_q          <= frame_clk;
      tick          <= frame_clk & ~fc_q;
      hit_pulse     <= 1'b0;
      landed_pulse  <= 1'b0;
      escaped_pulse <= 1'b0;

      // Wing flap runs while flying or escaping; the shot/fall poses overwrite frame.
      if (tick && (state == ST_FLY || state == ST_ESCAPE)
          && !(state == ST_FLY && (shot || fly_cnt == 16'(FLY_TICKS - 1)))) begin
        if (anim_cnt == 16'(ANIM_DIV - 1)) begin
          anim_cnt <= '0;
          frame    <= (frame == 3'(NUM_FLY_FRAMES - 1)) ? 3'd0 : frame + 3'd1;
        end else begin
          anim_cnt <= anim_cnt + 16'd1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (launch) begin
            state    <= ST_FLY;
            x        <= clamp10(int'(launch_x), X_MIN, X_HI);
            y        <= 10'(Y_HI);
            dir_left <= launch_left;
            dir_down <= 1'b0;
            fly_cnt  <= '0;
            anim_cnt <= '0;
            frame    <= '0;
          end
        end
        ST_FLY: begin
          if (shot) begin
            state     <= ST_SHOT;
            hit_pulse <= 1'b1;
            shot_cnt  <= '0;
            frame     <= 3'(NUM_FLY_FRAMES);
          end else if (tick) begin
            if (fly_cnt == 16'(FLY_TICKS - 1)) begin
              state <= ST_ESCAPE;
            end else begin
              fly_cnt <= fly_cnt + 16'd1;
              if (!dir_left) begin
                if ({1'b0, x} + 11'(X_STEP) > 11'(X_HI)) begin
                  x        <= 10'(X_HI);
                  dir_left <= 1'b1;
                end else begin
                  x <= x + 10'(X_STEP);
                end
              end else begin
                if (x < 10'(X_MIN + X_STEP)) begin
                  x        <= 10'(X_MIN);
                  dir_left <= 1'b0;
                end else begin
                  x <= x - 10'(X_STEP);
                end
              end
              if (dir_down) begin
                if ({1'b0, y} + 11'(Y_STEP) > 11'(Y_HI)) begin
                  y        <= 10'(Y_HI);
                  dir_down <= 1'b0;
                end else begin
                  y <= y + 10'(Y_STEP);
                end
              end else begin
                if (y < 10'(Y_MIN + Y_STEP)) begin
                  y        <= 10'(Y_MIN);
                  dir_down <= 1'b1;
                end else begin
                  y <= y - 10'(Y_STEP);
                end
              end
            end
          end
        end
        ST_SHOT: begin
          if (tick) begin
            if (shot_cnt == 16'(SHOT_TICKS - 1)) begin
              state <= ST_FALL;
              frame <= 3'(NUM_FLY_FRAMES + 1);
            end else begin
              shot_cnt <= shot_cnt + 16'd1;
            end
          end
        end
        ST_FALL: begin
          if (tick) begin
            if ({1'b0, y} + 11'(SPR_H - 1 + FALL_STEP) >= 11'(Y_MAX)) begin
              state        <= ST_IDLE;
              landed_pulse <= 1'b1;
            end else begin
              y <= y + 10'(FALL_STEP);
            end
          end
        end
        ST_ESCAPE: begin
          if (tick) begin
            if (y < 10'(Y_MIN + FALL_STEP)) begin
              state         <= ST_IDLE;
              escaped_pulse <= 1'b1;
            end else begin
              y <= y - 10'(FALL_STEP);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign visible    = (state != ST_IDLE);
  assign mirror     = dir_left && (state == ST_FLY || state == ST_ESCAPE);
  assign duck_state = state;
  assign is_duck    = in_box_q && visible && (rom_data != KEY_COLOR);

  sprite_addr_gen #(
    .SPR_W       (SPR_W),
    .SPR_H       (SPR_H),
    .SHEET_STRIDE(SHEET_STRIDE),
    .BASE_ADDR   (BASE_ADDR),
    .ADDR_W      (ADDR_W)
  ) u_addr (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .duck_x      (x),
    .duck_y      (y),
    .frame       (frame),
    .mirror      (mirror),
    .visible     (visible),
    .read_address(read_address),
    .in_box_q    (in_box_q)
  );

endmodule

// File: tb/tb_duck_sprite_engine.sv
// tb/tb_duck_sprite_engine.sv - directed self-checking bench for duck_sprite_engine
module tb_duck_sprite_engine;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_clk = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic        launch = 1'b0;
  logic [9:0]  launch_x = '0;
  logic        launch_left = 1'b0;
  logic        shot = 1'b0;
  logic [23:0] rom_data = '0;
  logic [18:0] read_address;
  logic        is_duck;
  logic [2:0]  duck_state;
  logic        hit_pulse;
  logic        landed_pulse;
  logic        escaped_pulse;

  int checks = 0;
  int errors = 0;
  int exp_x [7] = '{612, 614, 616, 618, 620, 620, 618};
  int n_ticks;
  int n_esc;

  duck_sprite_engine dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_clk    (frame_clk),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .launch       (launch),
    .launch_x     (launch_x),
    .launch_left  (launch_left),
    .shot         (shot),
    .rom_data     (rom_data),
    .read_address (read_address),
    .is_duck      (is_duck),
    .duck_state   (duck_state),
    .hit_pulse    (hit_pulse),
    .landed_pulse (landed_pulse),
    .escaped_pulse(escaped_pulse)
  );

  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_tick(input logic with_shot);
    frame_clk = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    shot      = with_shot;
    @(negedge Clk);
    shot      = 1'b0;
  endtask

  task automatic do_launch(input int lx, input logic left);
    launch      = 1'b1;
    launch_x    = 10'(lx);
    launch_left = left;
    @(negedge Clk);
    launch      = 1'b0;
  endtask

  task automatic rst_pulse();
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  // Pins the top-left corner at (px,py) using the bottom row of the box.
  task automatic probe(input string tag, input int px, input int py);
    DrawX = 10'(px); DrawY = 10'(py + 15); #1;
    chk({tag, "_in"}, 32'(read_address != 19'd550), 32'd1);
    DrawX = 10'(px - 1); #1;
    chk({tag, "_left"}, 32'(read_address), 32'd550);
    DrawX = 10'(px); DrawY = 10'(py + 16); #1;
    chk({tag, "_below"}, 32'(read_address), 32'd550);
  endtask

  initial begin
    DrawX = 10'd5; DrawY = 10'd5;
    repeat (3) @(negedge Clk);
    chk("rst_state", 32'(duck_state), 32'd0);
    chk("rst_addr", 32'(read_address), 32'd550);
    chk("rst_is_duck", 32'(is_duck), 32'd0);
    chk("rst_pulses", 32'({hit_pulse, landed_pulse, escaped_pulse}), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);

    // Right-edge clamp and bounce
    do_launch(610, 1'b0);
    chk("launch_state", 32'(duck_state), 32'd1);
    probe("launch_pos", 610, 385);
    for (int i = 0; i < 7; i++) begin
      do_tick(1'b0);
      probe($sformatf("bounce_x%0d", i), exp_x[i], 384 - i);
    end

    // Asynchronous reset mid-flight
    DrawX = 10'd5; DrawY = 10'd5;
    @(posedge Clk);
    #3 Reset_n = 1'b0;
    #1;
    chk("midrst_state", 32'(duck_state), 32'd0);
    chk("midrst_addr", 32'(read_address), 32'd550);
    chk("midrst_is_duck", 32'(is_duck), 32'd0);
    do_tick(1'b0);
    chk("midrst_hold_state", 32'(duck_state), 32'd0);
    chk("midrst_pulses", 32'({hit_pulse, landed_pulse, escaped_pulse}), 32'd0);
    Reset_n = 1'b1;
    @(negedge Clk);
    chk("postrst_state", 32'(duck_state), 32'd0);

    // Address, key-colour masking and one-cycle latency
    do_launch(100, 1'b0);
    DrawX = 10'd103; DrawY = 10'd387; rom_data = 24'h8a4f20; #1;
    chk("addr_right_f0", 32'(read_address), 32'd1833);
    chk("is_duck_early", 32'(is_duck), 32'd0);
    @(negedge Clk); #1;
    chk("is_duck_opaque", 32'(is_duck), 32'd1);
    rom_data = 24'h00ff00; #1;
    chk("is_duck_key", 32'(is_duck), 32'd0);
    DrawX = 10'd0; DrawY = 10'd0; rom_data = 24'h8a4f20;
    @(negedge Clk); #1;
    chk("is_duck_outside", 32'(is_duck), 32'd0);

    rst_pulse();
    do_launch(100, 1'b1);
    DrawX = 10'd103; DrawY = 10'd387; #1;
    chk("addr_left_f0", 32'(read_address), 32'd1846);

    rst_pulse();
    do_launch(100, 1'b0);
    repeat (7) do_tick(1'b0);
    DrawX = 10'd117; DrawY = 10'd380; #1;
    chk("addr_tick7_f0", 32'(read_address), 32'd1833);
    do_tick(1'b0);
    DrawX = 10'd119; DrawY = 10'd379; #1;
    chk("addr_right_f1", 32'(read_address), 32'd1853);

    // Shot, shot pose, fall and landing
    rst_pulse();
    do_launch(300, 1'b0);
    repeat (4) do_tick(1'b0);
    probe("preshot_pos", 308, 381);
    do_tick(1'b1);
    chk("hit_pulse", 32'(hit_pulse), 32'd1);
    chk("shot_state", 32'(duck_state), 32'd2);
    probe("shot_pos", 308, 381);
    DrawX = 10'd308; DrawY = 10'd396; #1;
    chk("shot_frame_addr", 32'(read_address), 32'd10210);
    @(negedge Clk);
    chk("hit_pulse_clear", 32'(hit_pulse), 32'd0);
    do_launch(10, 1'b0);
    chk("launch_in_shot", 32'(duck_state), 32'd2);
    repeat (29) do_tick(1'b0);
    chk("shot_29_ticks", 32'(duck_state), 32'd2);
    do_tick(1'b0);
    chk("fall_state", 32'(duck_state), 32'd3);
    DrawX = 10'd308; DrawY = 10'd396; #1;
    chk("fall_frame_addr", 32'(read_address), 32'd10230);
    do_tick(1'b0);
    probe("fall_step", 308, 384);
    chk("no_land_yet", 32'(landed_pulse), 32'd0);
    do_tick(1'b0);
    chk("landed_pulse", 32'(landed_pulse), 32'd1);
    chk("landed_idle", 32'(duck_state), 32'd0);
    @(negedge Clk);
    chk("landed_clear", 32'(landed_pulse), 32'd0);

    // Escape after FLY_TICKS without a shot
    do_launch(0, 1'b1);
    repeat (599) do_tick(1'b0);
    chk("fly_599", 32'(duck_state), 32'd1);
    do_tick(1'b0);
    chk("escape_state", 32'(duck_state), 32'd4);
    probe("escape_entry", 46, 213);
    do_tick(1'b0);
    probe("escape_step", 46, 210);
    do_launch(300, 1'b0);
    chk("launch_in_escape", 32'(duck_state), 32'd4);
    probe("escape_hold", 46, 210);
    n_ticks = 0;
    n_esc   = 0;
    while (duck_state != 3'd0 && n_ticks < 200) begin
      do_tick(1'b0);
      n_ticks++;
      if (escaped_pulse) n_esc++;
    end
    chk("escape_ticks", 32'(n_ticks), 32'd71);
    chk("escaped_once", 32'(n_esc), 32'd1);
    chk("escaped_idle", 32'(duck_state), 32'd0);
    @(negedge Clk);
    chk("escaped_clear", 32'(escaped_pulse), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/duck_sprite_engine.md
Name: duck_sprite_engine

Overview:
- Parametrised, animated successor to the static duck sprite block.
- Owns one duck's position, direction and life cycle: hidden, flying, shot, falling, escaping.
- Each frame tick it moves the duck with edge bounce, advances the wing-flap frame, and mirrors the sprite when flying left.
- Per pixel it produces the sprite-sheet ROM address and a key-colour-masked is_duck, registered one cycle to match a 1-cycle synchronous ROM. Sits between vga_controller (DrawX/DrawY) and the colour mapper.

Parameters:
- SPR_W, 20, sprite width in pixels
- SPR_H, 16, sprite height in pixels
- SHEET_STRIDE, 640, sheet row pitch in words
- BASE_ADDR, 550, sheet address of frame 0, pixel (0,0)
- NUM_FLY_FRAMES, 3, flap frames; shot frame = index NUM_FLY_FRAMES, fall frame = NUM_FLY_FRAMES+1, each SPR_W columns right of the previous
- ANIM_DIV, 8, frame ticks per flap frame
- X_STEP, 2, horizontal step per tick
- Y_STEP, 1, vertical step per tick
- FALL_STEP, 3, vertical step per tick when falling or escaping
- X_MIN, 0, playfield left bound
- X_MAX, 639, playfield right bound
- Y_MIN, 0, playfield top bound
- Y_MAX, 400, playfield bottom bound (grass line)
- FLY_TICKS, 600, ticks of flight before escape
- SHOT_TICKS, 30, ticks held in the shot pose
- KEY_COLOR, 24'h00ff00, transparent colour
- ADDR_W, 19, ROM address width

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous active-low reset
- frame_clk  in  1  vsync-rate frame strobe, same clock domain
- DrawX, DrawY  in  10 each  current pixel
- launch  in  1  start a flight; honoured only in IDLE
- launch_x  in  10  start X, top-left corner
- launch_left  in  1  initial horizontal direction (1 = left)
- shot  in  1  hit from trigger logic; honoured only in FLY
- rom_data  in  24  sheet pixel for the previous cycle's read_address
- read_address  out  ADDR_W  sheet address for the current DrawX/DrawY
- is_duck  out  1  opaque duck pixel for the pixel presented one cycle earlier
- duck_state  out  3  current state encoding
- hit_pulse, landed_pulse, escaped_pulse  out  1 each  one-cycle event strobes

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: state IDLE, X=0, Y=0, dir right/up, counters 0, frame 0, all outputs 0 (read_address = BASE_ADDR).
- Reset asserted mid-flight returns to IDLE immediately.
- tick = registered rising-edge detect of frame_clk, one Clk wide. Movement and counters update only on tick.
- State IDLE:
  - Duck hidden; is_duck forced 0.
  - launch -> FLY: X=launch_x clamped to [X_MIN, X_MAX-SPR_W+1], Y=Y_MAX-SPR_H+1, dir up, fly counter 0.
- State FLY, each tick:
  - nx = X±X_STEP. Right: if nx > X_MAX-SPR_W+1, set X=X_MAX-SPR_W+1 and flip left. Left: if X < X_MIN+X_STEP, set X=X_MIN and flip right.
  - Y is handled the same way with Y_STEP and bounds Y_MIN and Y_MAX-SPR_H+1.
  - When fly counter reaches FLY_TICKS-1 -> ESCAPE.
- FLY priority on the same cycle: shot, then escape, then move. shot -> SHOT and hit_pulse; position frozen.
- State SHOT: frame = shot frame. After SHOT_TICKS ticks -> FALL.
- State FALL: frame = fall frame; Y += FALL_STEP.
  - If Y+SPR_H-1+FALL_STEP >= Y_MAX -> IDLE with landed_pulse.
- State ESCAPE: X fixed; Y -= FALL_STEP.
  - If Y < Y_MIN+FALL_STEP -> IDLE with escaped_pulse.
- Animation: in FLY and ESCAPE, anim counter wraps at ANIM_DIV. On wrap, frame = (frame+1) mod NUM_FLY_FRAMES.
- mirror = dir left; only FLY and ESCAPE mirror.
- Pixel path, combinational in cycle n:
  - dx = DrawX-X, dy = DrawY-Y, compared at 11 bits unsigned.
  - in_box = DrawX>=X && dx<SPR_W && DrawY>=Y && dy<SPR_H.
  - col = mirror ? SPR_W-1-dx : dx.
  - read_address = BASE_ADDR + dy*SHEET_STRIDE + frame*SPR_W + col, truncated to ADDR_W. When !in_box, read_address = BASE_ADDR.
- Cycle n+1: is_duck = in_box_q && state!=IDLE && rom_data!=KEY_COLOR. Latency is exactly 1 Clk.
- launch in states other than IDLE and shot outside FLY are ignored.

Decomposition:
- duck_pkg: state enum (IDLE, FLY, SHOT, FALL, ESCAPE) and KEY_COLOR default.
- Sub-module sprite_addr_gen: in_box, mirror and address computation plus the 1-cycle in_box register.
- Motion and state machine stay in duck_sprite_engine.

Test Plan:
- Reset_n low mid-FLY -> duck_state=IDLE, is_duck=0, read_address=550 while low; no pulses.
- launch_x=610, right, X_STEP=2 -> X over ticks: 612,614,616,618,620,620 (dir flips left on the clamp tick),618.
- Duck at (100,200), right, frame 0, DrawX=103, DrawY=202 -> read_address=1833. Same pixel flying left -> 1846. In frame 1 and right -> 1853.
- rom_data=00ff00 the cycle after an in-box pixel -> is_duck=0. rom_data=8a4f20 -> is_duck=1, one cycle after the address.
- shot and frame tick on the same cycle in FLY -> hit_pulse=1, position unchanged. Shot frame lasts 30 ticks, then FALL +3/tick, then landed_pulse and IDLE.
- No shot for 600 ticks -> ESCAPE, Y decrements by 3, escaped_pulse once, then IDLE. A launch during ESCAPE is ignored.
